// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU register file and its scoreboard.
package cpu_pkg;

  localparam int          DATA_W_DEF   = 32;
  localparam int          ADDR_W_DEF   = 5;
  localparam int          SP_INDEX_DEF = 29;
  localparam logic [31:0] SP_INIT_DEF  = 32'h0000_0400;
  localparam int          ZERO_REG     = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage : cpu_pkg

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: hardwired-zero check, optional write bypass,
// and busy masking when the outstanding result is being written back now.
module regfile_sb_rdport
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              stored_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic is_zero_s;
  logic fwd_hit_s;

  assign is_zero_s = (rd_addr == ZERO_IDX);
  assign fwd_hit_s = wr_en && (wr_addr == rd_addr) && !is_zero_s;

  // Select read data and busy flag; register 0 is never busy and always reads zero.
  always_comb begin
    rd_data = {DATA_W{1'b0}};
    rd_busy = 1'b0;
    if (is_zero_s) begin
      rd_data = {DATA_W{1'b0}};
      rd_busy = 1'b0;
    end else if ((BYPASS != 0) && fwd_hit_s) begin
      // The writeback in flight both supplies the data and retires the busy bit.
      rd_data = wr_data;
      rd_busy = 1'b0;
    end else begin
      rd_data = stored_data;
      rd_busy = stored_busy;
    end
  end

endmodule : regfile_sb_rdport

// File: rtl/regfile_sb.sv
// General-purpose register file with N read ports, hardwired-zero r0,
// configurable stack-pointer reset value and a per-register busy scoreboard.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                NUM_RD   = 2,
  parameter int                BYPASS   = 1,
  parameter int                SP_INDEX = SP_INDEX_DEF,
  parameter logic [DATA_W-1:0] SP_INIT  = SP_INIT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [DEPTH-1:0]  busy_nxt_s;
  logic [ADDR_W:0]   busy_cnt_r;
  logic [ADDR_W:0]   busy_cnt_nxt_s;
  logic              set_s;
  logic              clr_s;
  logic              inc_s;
  logic              dec_s;

  assign set_s = iss_en && (iss_addr != ZERO_IDX);
  assign clr_s = wr_en && (wr_addr != ZERO_IDX);

  // Register storage: reset to zero except the stack pointer; r0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= (i == SP_INDEX) ? SP_INIT : {DATA_W{1'b0}};
      end
    end else if (clr_s) begin
      mem_r[wr_addr] <= wr_data;
    end else begin
      mem_r[wr_addr] <= mem_r[wr_addr];
    end
  end

  // Next busy vector and count deltas; a same-index issue overrides the clear
  // because the newly issued producer is still outstanding.
  always_comb begin
    busy_nxt_s = busy_r;
    inc_s      = 1'b0;
    dec_s      = 1'b0;
    if (clr_s) begin
      busy_nxt_s[wr_addr] = 1'b0;
      dec_s = busy_r[wr_addr] && !(set_s && (iss_addr == wr_addr));
    end else begin
      dec_s = 1'b0;
    end
    if (set_s) begin
      busy_nxt_s[iss_addr] = 1'b1;
      inc_s = !busy_r[iss_addr];
    end else begin
      inc_s = 1'b0;
    end
  end

  // Incremental update of the busy count from the set/clear deltas.
  always_comb begin
    busy_cnt_nxt_s = busy_cnt_r;
    case ({inc_s, dec_s})
      2'b10:   busy_cnt_nxt_s = busy_cnt_r + CNT_ONE;
      2'b01:   busy_cnt_nxt_s = busy_cnt_r - CNT_ONE;
      default: busy_cnt_nxt_s = busy_cnt_r;
    endcase
  end

  // Scoreboard state and registered busy count; reset overrides issue and write.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r     <= {DEPTH{1'b0}};
      busy_cnt_r <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= busy_cnt_nxt_s;
    end
  end

  assign busy_cnt = busy_cnt_r;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    assign addr_s = rd_addr[k*ADDR_W +: ADDR_W];

    regfile_sb_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_rdport (
      .rd_addr     (addr_s),
      .stored_data (mem_r[addr_s]),
      .stored_busy (busy_r[addr_s]),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_data     (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy     (rd_busy[k])
    );
  end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance
// share the same stimulus; expected values are written out by hand.
module tb_regfile_sb;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic        wr_en;
  reg_idx_t    wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  reg_idx_t    iss_addr;

  logic [63:0] rd_data_bp;
  logic [1:0]  rd_busy_bp;
  logic [5:0]  busy_cnt_bp;
  logic [63:0] rd_data_nb;
  logic [1:0]  rd_busy_nb;
  logic [5:0]  busy_cnt_nb;

  int n_checks;
  int n_pass;

  regfile_sb #(.BYPASS(1)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_bp),
    .rd_busy  (rd_busy_bp),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_cnt (busy_cnt_bp)
  );

  regfile_sb #(.BYPASS(0)) u_dut_nb (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_nb),
    .rd_busy  (rd_busy_nb),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_cnt (busy_cnt_nb)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {5'(a1), 5'(a0)};
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    iss_en   = 1'b0;
    wr_addr  = 5'd0;
    iss_addr = 5'd0;
    wr_data  = 32'h0000_0000;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    rd_addr  = 10'd0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state on both ports of both instances.
    check_eq("rst_cnt_bp", 32'(busy_cnt_bp), 32'd0);
    check_eq("rst_cnt_nb", 32'(busy_cnt_nb), 32'd0);
    for (int i = 0; i < 32; i++) begin
      set_rd(i, 31 - i);
      check_eq($sformatf("rst_p0_r%0d", i), rd_data_bp[31:0],
               (i == 29) ? 32'h0000_0400 : 32'h0000_0000);
      check_eq($sformatf("rst_p1_r%0d", 31 - i), rd_data_bp[63:32],
               ((31 - i) == 29) ? 32'h0000_0400 : 32'h0000_0000);
      check_eq($sformatf("rst_nb_p0_r%0d", i), rd_data_nb[31:0],
               (i == 29) ? 32'h0000_0400 : 32'h0000_0000);
      check_eq($sformatf("rst_busy_%0d", i), 32'(rd_busy_bp), 32'd0);
    end

    // Same-cycle write of r5 with bypass vs without.
    set_rd(5, 0);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    #1;
    check_eq("byp_r5_bp", rd_data_bp[31:0], 32'hDEAD_BEEF);
    check_eq("byp_r5_nb", rd_data_nb[31:0], 32'h0000_0000);
    tick();
    idle();
    #1;
    check_eq("r5_next_bp", rd_data_bp[31:0], 32'hDEAD_BEEF);
    check_eq("r5_next_nb", rd_data_nb[31:0], 32'hDEAD_BEEF);
    check_eq("r5_cnt_nonbusy", 32'(busy_cnt_bp), 32'd0);
    set_rd(5, 5);
    check_eq("same_idx_p0", rd_data_bp[31:0], 32'hDEAD_BEEF);
    check_eq("same_idx_p1", rd_data_bp[63:32], 32'hDEAD_BEEF);

    // Writes and issues to r0 have no effect.
    set_rd(0, 0);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
    iss_en = 1'b1; iss_addr = 5'd0;
    #1;
    check_eq("r0_same_bp", rd_data_bp[31:0], 32'h0000_0000);
    check_eq("r0_same_nb", rd_data_nb[31:0], 32'h0000_0000);
    tick();
    idle();
    #1;
    check_eq("r0_after_bp", rd_data_bp[31:0], 32'h0000_0000);
    check_eq("r0_after_p1", rd_data_bp[63:32], 32'h0000_0000);
    check_eq("r0_busy", 32'(rd_busy_bp), 32'd0);
    check_eq("r0_cnt", 32'(busy_cnt_bp), 32'd0);

    // Issue r7, then write it back.
    set_rd(7, 0);
    iss_en = 1'b1; iss_addr = 5'd7;
    #1;
    check_eq("iss7_same_busy", 32'(rd_busy_bp[0]), 32'd0);
    tick();
    idle();
    #1;
    check_eq("iss7_busy_bp", 32'(rd_busy_bp[0]), 32'd1);
    check_eq("iss7_busy_nb", 32'(rd_busy_nb[0]), 32'd1);
    check_eq("iss7_cnt", 32'(busy_cnt_bp), 32'd1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0055;
    #1;
    check_eq("wb7_busy_bp", 32'(rd_busy_bp[0]), 32'd0);
    check_eq("wb7_data_bp", rd_data_bp[31:0], 32'h0000_0055);
    check_eq("wb7_busy_nb", 32'(rd_busy_nb[0]), 32'd1);
    check_eq("wb7_data_nb", rd_data_nb[31:0], 32'h0000_0000);
    tick();
    idle();
    #1;
    check_eq("wb7_cnt_bp", 32'(busy_cnt_bp), 32'd0);
    check_eq("wb7_cnt_nb", 32'(busy_cnt_nb), 32'd0);
    check_eq("wb7_after_busy", 32'(rd_busy_nb[0]), 32'd0);
    check_eq("wb7_after_data", rd_data_nb[31:0], 32'h0000_0055);

    // r9 busy, then issue+write r9 in the same cycle: set wins.
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    idle();
    #1;
    check_eq("iss9_cnt", 32'(busy_cnt_bp), 32'd1);
    iss_en = 1'b1; iss_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0099;
    tick();
    idle();
    set_rd(9, 0);
    check_eq("r9_still_busy", 32'(rd_busy_bp[0]), 32'd1);
    check_eq("r9_cnt", 32'(busy_cnt_bp), 32'd1);
    check_eq("r9_data", rd_data_bp[31:0], 32'h0000_0099);

    // Issue r10 while retiring r9: net count change zero.
    iss_en = 1'b1; iss_addr = 5'd10;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0999;
    tick();
    idle();
    set_rd(9, 10);
    check_eq("net0_cnt", 32'(busy_cnt_bp), 32'd1);
    check_eq("net0_busy", 32'(rd_busy_bp), 32'b10);

    // Issue r3 and r4, then reset together with an issue to r6.
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    iss_addr = 5'd4;
    tick();
    idle();
    #1;
    check_eq("pre_rst_cnt", 32'(busy_cnt_bp), 32'd3);
    reset = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
    tick();
    reset = 1'b0;
    idle();
    #1;
    check_eq("post_rst_cnt_bp", 32'(busy_cnt_bp), 32'd0);
    check_eq("post_rst_cnt_nb", 32'(busy_cnt_nb), 32'd0);
    set_rd(3, 4);
    check_eq("post_rst_busy34", 32'(rd_busy_bp), 32'd0);
    set_rd(6, 10);
    check_eq("post_rst_busy6", 32'(rd_busy_bp), 32'd0);
    set_rd(29, 5);
    check_eq("post_rst_sp", rd_data_bp[31:0], 32'h0000_0400);
    check_eq("post_rst_r5", rd_data_bp[63:32], 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the CPU general-purpose register file. It adds N combinational read ports, optional write-to-read bypass, a hardwired-zero register, and a configurable stack-pointer reset value. It also keeps a per-register busy scoreboard for the pipelined core. It sits between decode (reads, issue) and writeback (write, busy clear).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return stored value only
SP_INDEX, 29, index of the stack-pointer register
SP_INIT, 32'h0000_0400, reset value of register SP_INDEX; all other registers reset to 0

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous reset, active-high
rd_addr  in  NUM_RD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  1 = register read on port k has a write outstanding
wr_en  in  1  writeback write enable
wr_addr  in  ADDR_W  writeback index
wr_data  in  DATA_W  writeback data
iss_en  in  1  issue: mark iss_addr busy
iss_addr  in  ADDR_W  destination register of the issued instruction
busy_cnt  out  ADDR_W+1  number of registers currently busy (registered)

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on reset: sampled on the rising clk edge.
- Reset effects: all registers become 0 except SP_INDEX, which becomes SP_INIT. All busy bits clear and busy_cnt becomes 0. Reset overrides wr_en and iss_en in the same cycle.
- Register 0 reads 0 on every port. Writes and issues to index 0 are ignored. rd_busy for index 0 is always 0.
- Write: when wr_en is high and wr_addr != 0, mem[wr_addr] takes wr_data at the clock edge.
- Read latency is 0 (combinational from rd_addr).
  - BYPASS=1: if wr_en is high, wr_addr == rd_addr[k] and the index is nonzero, rd_data[k] = wr_data. Otherwise rd_data[k] = mem[rd_addr[k]].
  - BYPASS=0: rd_data[k] = mem[rd_addr[k]]. The written value is visible from the next cycle.
- Scoreboard: one busy bit per register.
  - Set at the edge when iss_en is high and iss_addr != 0.
  - Cleared at the edge when wr_en is high and wr_addr != 0.
  - Set and clear on the same index in the same cycle: set wins. The bit ends 1, because the new producer is outstanding.
  - Issue to an already-busy register: bit stays 1. No count change, no error.
  - Write to a non-busy register: data is written, bit stays 0.
- rd_busy[k] = busy[rd_addr[k]] & ~(wr_en & wr_addr == rd_addr[k]) when BYPASS=1. When BYPASS=0 it is busy[rd_addr[k]] only.
  - A same-cycle issue does not affect rd_busy until the next cycle.
- busy_cnt is a registered count of busy bits. It is updated incrementally:
  - +1 if the issue newly sets a bit.
  - -1 if the write clears a bit that is not also being set.
  - Both on different indices: net 0.
  - Range 0..2**ADDR_W-1; it never wraps because register 0 is never busy.
- Multiple read ports addressing the same index all return the same value. There are no read-port conflicts.

Decomposition:
- Shared package cpu_pkg holds: DATA_W/ADDR_W defaults, SP_INDEX, SP_INIT, the ZERO_REG = 0 constant, and a reg_idx_t typedef.
- One sub-module is natural: regfile_sb_rdport. It is instantiated NUM_RD times with a generate loop and contains one port's zero-check, bypass mux and busy mask.
- The scoreboard and busy_cnt stay in the top module.

Test Plan:
- Reset, then read all 32 indices on both ports -> every value 0 except r29 = 0x00000400. rd_busy = 0 and busy_cnt = 0.
- Write r5 = 0xDEADBEEF while rd_addr0 = 5 in the same cycle -> BYPASS=1: rd_data0 = 0xDEADBEEF that cycle. BYPASS=0: old value (0) that cycle, 0xDEADBEEF the next cycle.
- Write r0 = 0x12345678 and issue r0 -> rd_data for r0 stays 0, rd_busy stays 0, busy_cnt stays 0.
- Issue r7 -> next cycle rd_busy = 1 for r7 and busy_cnt = 1. Then writeback r7 = 0x55 -> rd_busy = 0 in the same cycle (bypass), rd_data = 0x55, busy_cnt = 0 next cycle.
- Issue r9 and writeback r9 in the same cycle while r9 is already busy -> r9 stays busy, busy_cnt unchanged, mem[r9] updated.
- Issue r3 and r4 on consecutive cycles, then assert reset alongside iss_en for r6 -> after the reset edge busy_cnt = 0, all busy bits 0, r29 = 0x00000400.
